// File: rtl/bbox_project_seq.sv
// Projects one axis-aligned LiDAR box onto the camera image via a shared restoring divider.
// Latency: 106 cycles with divisions, 2 cycles when the box lies behind the near plane (accept edge counted as 1).
// Backpressure: one box in flight; ready_out low until the result handshakes, outputs held while ready_in is low.
module bbox_project_seq #(
  parameter int                 COORD_W = 16,
  parameter int                 FRAC    = 9,
  parameter int                 PIX_W   = 11,
  parameter int                 IMG_W   = 1242,
  parameter int                 IMG_H   = 375,
  parameter int                 FX      = 720,
  parameter int                 FY      = 720,
  parameter int                 CX      = 621,
  parameter int                 CY      = 187,
  parameter logic [COORD_W-1:0] NEAR    = COORD_W'(1) << FRAC,
  parameter int                 TAG_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic [COORD_W-1:0] min_x,
  input  logic [COORD_W-1:0] min_y,
  input  logic [COORD_W-1:0] min_z,
  input  logic [COORD_W-1:0] max_x,
  input  logic [COORD_W-1:0] max_y,
  input  logic [COORD_W-1:0] max_z,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               valid_out,
  input  logic               ready_in,
  output logic [PIX_W-1:0]   HorMinOut,
  output logic [PIX_W-1:0]   HorMaxOut,
  output logic [PIX_W-1:0]   VerMinOut,
  output logic [PIX_W-1:0]   VerMaxOut,
  output logic               visible,
  output logic [TAG_W-1:0]   tag_out,
  output logic [63:0]        bbox
);

  localparam int QW   = PIX_W + 1;                 // quotient width
  localparam int CW   = PIX_W + 3;                 // signed candidate width
  localparam int FMAX = (FX > FY) ? FX : FY;
  localparam int FW   = $clog2(FMAX + 1);
  localparam int WW   = COORD_W + FW + QW;         // holds F*|n| and x << QW
  localparam int SW   = $clog2(QW + 1);
  localparam logic signed [CW-1:0] U_HI = CW'(IMG_W - 1);
  localparam logic signed [CW-1:0] V_HI = CW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, DIV, CLAMP, OUT} state_t;

  state_t                      state_q, state_d;
  logic [2:0]                  idx_q;              // [2]: 0=u/1=v, [1]: 0=xe_min/1=xe_max, [0]: 0=max/1=min
  logic [SW-1:0]               cnt_q;              // 0 = load, 1..QW = one quotient bit each
  logic [WW-1:0]               rem_q, rem_d;
  logic [QW-1:0]               quo_q, quo_d;
  logic signed [COORD_W-1:0]   min_y_q, max_y_q, min_z_q, max_z_q;
  logic [COORD_W-1:0]          xe_min_q, xe_max_q;
  logic                        near_inv_q;
  logic [TAG_W-1:0]            tag_q;
  logic signed [CW-1:0]        umin_q, umax_q, vmin_q, vmax_q;
  logic [PIX_W-1:0]            hor_min_q, hor_max_q, ver_min_q, ver_max_q;
  logic                        vis_q;

  logic signed [COORD_W-1:0]   n_sel;
  logic [COORD_W-1:0]          x_sel, n_abs;
  logic                        n_neg;
  logic [FW-1:0]               f_sel;
  logic [WW-1:0]               num, dsh;
  logic [SW-1:0]               sh;
  logic signed [CW-1:0]        base, q_ext, cand;
  logic                        vis;
  logic                        div_last;

  function automatic logic [PIX_W-1:0] clampv(input logic signed [CW-1:0] v,
                                              input logic signed [CW-1:0] hi);
    if (v[CW-1])    return '0;
    else if (v > hi) return PIX_W'(hi);
    else             return PIX_W'(v);
  endfunction

  assign div_last  = (cnt_q == SW'(QW));
  assign ready_out = (state_q == IDLE) && !rst;
  assign valid_out = (state_q == OUT);
  assign HorMinOut = hor_min_q;
  assign HorMaxOut = hor_max_q;
  assign VerMinOut = ver_min_q;
  assign VerMaxOut = ver_max_q;
  assign visible   = vis_q;
  assign tag_out   = tag_q;
  assign bbox      = {16'(hor_min_q), 16'(ver_min_q), 16'(hor_max_q), 16'(ver_max_q)};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: near-clipped boxes skip the divider entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_in) state_d = ($signed(max_x) < $signed(NEAR)) ? CLAMP : DIV;
      DIV:     if (div_last && idx_q == 3'd7) state_d = CLAMP;
      CLAMP:   state_d = OUT;
      OUT:     if (ready_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand select, one restoring-division step and the resulting image-plane candidate.
  always_comb begin
    n_sel = idx_q[2] ? (idx_q[0] ? min_z_q : max_z_q) : (idx_q[0] ? min_y_q : max_y_q);
    x_sel = idx_q[1] ? xe_max_q : xe_min_q;
    n_neg = n_sel[COORD_W-1];
    n_abs = n_neg ? $unsigned(-n_sel) : $unsigned(n_sel);
    f_sel = idx_q[2] ? FW'(FY) : FW'(FX);
    num   = WW'(f_sel) * WW'(n_abs);
    sh    = SW'(QW) - cnt_q;
    dsh   = WW'(x_sel) << sh;
    rem_d = rem_q;
    quo_d = quo_q;
    if (cnt_q == '0) begin
      // Saturate up front; a zero remainder then keeps every bit set through the steps.
      if (num >= dsh) begin
        rem_d = '0;
        quo_d = '1;
      end else begin
        rem_d = num;
        quo_d = '0;
      end
    end else if (rem_q >= dsh) begin
      rem_d = rem_q - dsh;
      quo_d = quo_q | (QW'(1) << sh);
    end
    base  = idx_q[2] ? CW'(CY) : CW'(CX);
    q_ext = CW'(quo_d);
    cand  = n_neg ? base + q_ext : base - q_ext;
  end

  // Visibility test on the running extents.
  always_comb begin
    vis = !near_inv_q && !umax_q[CW-1] && !(umin_q > U_HI) && !vmax_q[CW-1] && !(vmin_q > V_HI);
  end

  // Datapath: capture box, iterate divider, track extents, register clamped result.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0; cnt_q <= '0; rem_q <= '0; quo_q <= '0;
      min_y_q <= '0; max_y_q <= '0; min_z_q <= '0; max_z_q <= '0;
      xe_min_q <= '0; xe_max_q <= '0; near_inv_q <= 1'b0; tag_q <= '0;
      umin_q <= '0; umax_q <= '0; vmin_q <= '0; vmax_q <= '0;
      hor_min_q <= '0; hor_max_q <= '0; ver_min_q <= '0; ver_max_q <= '0;
      vis_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (valid_in) begin
          min_y_q    <= $signed(min_y);
          max_y_q    <= $signed(max_y);
          min_z_q    <= $signed(min_z);
          max_z_q    <= $signed(max_z);
          xe_min_q   <= ($signed(min_x) < $signed(NEAR)) ? NEAR : min_x;
          xe_max_q   <= ($signed(max_x) < $signed(NEAR)) ? NEAR : max_x;
          near_inv_q <= ($signed(max_x) < $signed(NEAR));
          tag_q      <= tag_in;
          idx_q      <= '0;
          cnt_q      <= '0;
        end
        DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (div_last) begin
            cnt_q <= '0;
            idx_q <= idx_q + 3'd1;
            // The first candidate of each axis seeds both extents.
            if (idx_q[2]) begin
              if (idx_q[1:0] == 2'd0 || cand < vmin_q) vmin_q <= cand;
              if (idx_q[1:0] == 2'd0 || cand > vmax_q) vmax_q <= cand;
            end else begin
              if (idx_q[1:0] == 2'd0 || cand < umin_q) umin_q <= cand;
              if (idx_q[1:0] == 2'd0 || cand > umax_q) umax_q <= cand;
            end
          end else begin
            cnt_q <= cnt_q + SW'(1);
          end
        end
        CLAMP: begin
          vis_q     <= vis;
          hor_min_q <= vis ? clampv(umin_q, U_HI) : '0;
          hor_max_q <= vis ? clampv(umax_q, U_HI) : '0;
          ver_min_q <= vis ? clampv(vmin_q, V_HI) : '0;
          ver_max_q <= vis ? clampv(vmax_q, V_HI) : '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bbox_project_seq.md
# bbox_project_seq

Parametrised, sequential successor to the fixed-camera 3D-to-image bounding-box projector. Takes one axis-aligned LiDAR box (signed fixed-point metres, x forward / y left / z up) per handshake and projects its 8 corners through a pinhole model with parametrised intrinsics. Image size, near plane and tag width are also parameters. It time-shares one restoring divider, clamps the result to the image, and flags boxes that are behind the camera or off-image. It sits between the LiDAR clustering stage and the camera-domain bbox consumer.

## Interface
- COORD_W, 16, coordinate width, two's complement
- FRAC, 9, fractional bits of coordinates (s6.9 at default)
- PIX_W, 11, pixel coordinate width
- IMG_W, 1242, image width in pixels
- IMG_H, 375, image height in pixels
- FX, 720, horizontal focal length in pixels, unsigned integer
- FY, 720, vertical focal length in pixels, unsigned integer
- CX, 621, principal point column
- CY, 187, principal point row
- NEAR, 16'h0200, near-plane x in raw coordinate units (1.0 m)
- TAG_W, 8, width of pass-through box tag
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  upstream box valid
- ready_out  out  1  block can accept a box
- min_x, min_y, min_z, max_x, max_y, max_z  in  COORD_W each  box extents, signed
- tag_in  in  TAG_W  box identifier
- valid_out  out  1  result valid
- ready_in  in  1  downstream accepts result
- HorMinOut, HorMaxOut, VerMinOut, VerMaxOut  out  PIX_W each  clamped pixel box
- visible  out  1  box projects onto the image
- tag_out  out  TAG_W  tag of the result
- bbox  out  64  {zero-pad to 16, HorMinOut}, {pad, VerMinOut}, {pad, HorMaxOut}, {pad, VerMaxOut}, MSB first

## Operation
- States: IDLE, DIV, CLAMP, OUT.
- IDLE: ready_out = 1. On valid_in && ready_out, register all inputs and tag_in.
- Near-plane clip: xe_min = max(min_x, NEAR); xe_max = max(max_x, NEAR).
  - If max_x < NEAR, the box is invisible: go directly to CLAMP and skip the divisions.
  - Otherwise go to DIV.
- DIV runs 8 divisions in a fixed order:
  - u candidates: (y, x) = (max_y, xe_min), (min_y, xe_min), (max_y, xe_max), (min_y, xe_max).
  - v candidates: (z, x) = (max_z, xe_min), (min_z, xe_min), (max_z, xe_max), (min_z, xe_max).
- Each division: q = floor(F·|n_raw| / x_raw), computed unsigned with restoring division, one quotient bit per cycle.
  - Quotient width QW = PIX_W+1, so 13 cycles per division including load.
  - If the numerator is ≥ x_raw·2^QW, q saturates to 2^QW−1.
- Candidate value:
  - u = CX − sign(y)·q.
  - v = CY − sign(z)·q.
  - Both are held signed, PIX_W+3 bits wide.
  - Running min/max of u and v are updated as each division completes.
- CLAMP:
  - visible = 0 if max_x < NEAR, or umax < 0, or umin > IMG_W−1, or vmax < 0, or vmin > IMG_H−1.
  - If visible, each bound is clamped to [0, IMG_W−1] (horizontal) or [0, IMG_H−1] (vertical).
  - If not visible, all four pixel outputs are 0.
- OUT: valid_out = 1 with outputs stable until ready_in is sampled high, then return to IDLE.
- min > max on any axis is not checked; the result is whatever the corners give.

## Timing
- Reset values: valid_out 0, ready_out 0 while rst is high, all pixel outputs 0, bbox 0, visible 0, tag_out 0, state IDLE.
- Reset mid-operation aborts the box with no output; ready_out = 1 on the first cycle after rst falls.
- Latency from the accept edge to valid_out high:
  - Visible path: 1 + 8×13 + 1 = 106 cycles.
  - Invisible-by-near path: 2 cycles.
- No new box is accepted until the OUT handshake completes. The IDLE cycle after a handshake is mandatory, so throughput is at most one box per 107 cycles.
- valid_out must not depend combinationally on ready_in; outputs hold under backpressure.

## Test plan
- Box min=(0x0800, 0xFC00, 0xFC00), max=(0x0C00, 0x0400, 0x0000), tag 0x5A, ready_in=1:
  - After 106 cycles: Hor 261..981, Ver 187..374 (clamped from 547), visible=1, tag_out=0x5A.
  - bbox = 0x0105_00BB_03D5_0176.
- max_x = 0x0100 (< NEAR): valid_out 2 cycles after accept, visible=0, all pixel outputs 0.
- min_x = 0x0000, max_x = 0x0800, y = ±0.5 m: min_x is clipped to NEAR, giving q = 360 → Hor 261..981.
- Box fully left, min_y = 0x0A00, max_y = 0x0C00 at x = 4 m: umax = 621 − 900 < 0 → visible=0.
- Hold ready_in=0 for 20 cycles after valid_out rises:
  - Outputs remain stable and ready_out stays 0.
  - A second valid_in in that window is not accepted.
  - Handshake completes on the first cycle ready_in=1.
- Assert rst at cycle 50 of DIV: valid_out stays 0, no stale output is produced, and the next box returns correct results.
